// File: rtl/lcg_stream_checker.sv
// rtl/lcg_stream_checker.sv - self-synchronising checker for a 64-bit LCG state stream
//
// Predicts each word of the stream from the previous one (next = MULT*prev + INC
// mod 2^64). It locks after LOCK_COUNT consecutive hits, and once locked it counts
// mismatches.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   clear       synchronous clear; returns to IDLE and zeroes both counters
//   in_valid    in_data carries a new stream word (no backpressure)
//   in_data     64-bit LCG state word
//   locked      high while in LOCKED
//   mismatch    one-cycle pulse when a word accepted in LOCKED misses
//   err_count   saturating count of mismatches seen in LOCKED
//   word_count  count of accepted words, wraps modulo 2^32
//   state       00 IDLE, 01 TRAIN, 10 LOCKED
module lcg_stream_checker #(
  parameter logic [63:0] MULT       = 64'd6364136223846793005,
  parameter logic [63:0] INC        = 64'd1442695040888963407,
  parameter int          LOCK_COUNT = 4,
  parameter int          ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      word_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TRAIN  = 2'b01,
    LOCKED = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

  state_t      st;
  logic [63:0] pred;
  logic [7:0]  run;
  logic [63:0] pred_next;
  logic        hit;

  // Low 64 bits only; carries beyond bit 63 are discarded by the operand width.
  assign pred_next = in_data * MULT + INC;
  // pred is the prediction made from the previous word, before this word updates it.
  assign hit       = (in_data == pred);
  assign state     = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
      run        <= '0;
      pred       <= '0;
    end else begin
      mismatch <= 1'b0;
      if (clear) begin
        // clear wins over a word presented in the same cycle; pred is left alone
        // because IDLE ignores it.
        st         <= IDLE;
        locked     <= 1'b0;
        err_count  <= '0;
        word_count <= '0;
        run        <= '0;
      end else begin
        if (st == BAD) begin
          st     <= IDLE;
          locked <= 1'b0;
          run    <= '0;
        end
        if (in_valid) begin
          pred       <= pred_next;
          word_count <= word_count + 32'd1;
          case (st)
            IDLE: begin
              st  <= TRAIN;
              run <= '0;
            end
            TRAIN: begin
              if (hit) begin
                if (run + 8'd1 == LOCK_N) begin
                  st     <= LOCKED;
                  locked <= 1'b1;
                  run    <= '0;
                end else begin
                  run <= run + 8'd1;
                end
              end else begin
                run <= '0;
              end
            end
            LOCKED: begin
              if (!hit) begin
                // pred reloads from the offending word above, so the checker
                // retrains on whatever sequence now follows.
                mismatch <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                st     <= TRAIN;
                locked <= 1'b0;
                run    <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcg_stream_checker.sv
// tb/tb_lcg_stream_checker.sv - scoreboard bench for lcg_stream_checker
module tb_lcg_stream_checker;

  localparam logic [63:0] MULT = 64'd6364136223846793005;
  localparam logic [63:0] INC  = 64'd1442695040888963407;
  localparam logic [1:0]  S_IDLE = 2'b00, S_TRAIN = 2'b01, S_LOCKED = 2'b10;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid;
  logic [63:0] in_data;

  logic        locked, mismatch;
  logic [15:0] err_count;
  logic [31:0] word_count;
  logic [1:0]  state;

  logic        locked_b, mismatch_b;
  logic [1:0]  err_count_b;
  logic [31:0] word_count_b;
  logic [1:0]  state_b;

  lcg_stream_checker u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .mismatch(mismatch), .err_count(err_count),
    .word_count(word_count), .state(state)
  );

  lcg_stream_checker #(.ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_b), .mismatch(mismatch_b), .err_count(err_count_b),
    .word_count(word_count_b), .state(state_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  st;
    logic        mm;
    logic [15:0] err;
    logic [31:0] wc;
    logic [15:0] id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_err;
  logic [31:0] exp_wc;
  logic [63:0] last;
  int          step_id;

  function automatic logic [63:0] lcg(input logic [63:0] x);
    return x * MULT + INC;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input logic v, input logic [63:0] d, input logic clr,
                      input logic [1:0] est, input logic emm);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = clr;
    if (clr) begin
      exp_wc  = 0;
      exp_err = 0;
    end else if (v) begin
      exp_wc = exp_wc + 1;
    end
    if (emm) exp_err = exp_err + 1;
    step_id++;
    sb.push_back('{est, emm, exp_err, exp_wc, 16'(step_id)});
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " state"}, state, 0);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " mismatch"}, mismatch, 0);
    chk({tag, " err_count"}, err_count, 0);
    chk({tag, " word_count"}, word_count, 0);
    chk({tag, " sat err_count"}, err_count_b, 0);
  endtask

  // Monitor: pops one expectation per edge that had stimulus and compares.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("step%0d state", e.id), state, e.st);
        chk($sformatf("step%0d locked", e.id), locked, e.st == S_LOCKED);
        chk($sformatf("step%0d mismatch", e.id), mismatch, e.mm);
        chk($sformatf("step%0d err_count", e.id), err_count, e.err);
        chk($sformatf("step%0d word_count", e.id), word_count, e.wc);
        chk($sformatf("step%0d sat err_count", e.id), err_count_b,
            (e.err > 16'd3) ? 64'd3 : 64'(e.err));
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    exp_wc = 0; exp_err = 0; step_id = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Lock-in from word 0: IDLE -> TRAIN, then 4 hits -> LOCKED on word 5.
    last = 64'd0;
    step(1'b1, last, 1'b0, S_TRAIN, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      last = lcg(last);
      step(1'b1, last, 1'b0, (i == 4) ? S_LOCKED : S_TRAIN, 1'b0);
    end

    // Corrupt bit 0 while locked, then resume the true sequence.
    step(1'b1, lcg(last) ^ 64'd1, 1'b0, S_TRAIN, 1'b1);
    last = lcg(last);
    last = lcg(last);
    step(1'b1, last, 1'b0, S_TRAIN, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      last = lcg(last);
      step(1'b1, last, 1'b0, (i == 4) ? S_LOCKED : S_TRAIN, 1'b0);
    end

    // Idle gap while locked, then a correct word.
    repeat (10) step(1'b0, 64'hDEAD_BEEF, 1'b0, S_LOCKED, 1'b0);
    last = lcg(last);
    step(1'b1, last, 1'b0, S_LOCKED, 1'b0);

    // Clear together with a valid word: word dropped, counters zero.
    step(1'b1, lcg(last), 1'b1, S_IDLE, 1'b0);

    // Alternating correct/corrupted words never lock.
    last = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i % 2 == 1) ? (last ^ 64'd1) : last, 1'b0, S_TRAIN, 1'b0);
      last = lcg(last);
    end

    // Five lock/miss cycles: 16-bit counter reaches 5, 2-bit counter sticks at 3.
    step(1'b0, 64'd0, 1'b1, S_IDLE, 1'b0);
    last = 64'hCAFE;
    step(1'b1, last, 1'b0, S_TRAIN, 1'b0);
    repeat (5) begin
      for (int i = 1; i <= 4; i++) begin
        last = lcg(last);
        step(1'b1, last, 1'b0, (i == 4) ? S_LOCKED : S_TRAIN, 1'b0);
      end
      last = lcg(last) ^ 64'd1;
      step(1'b1, last, 1'b0, S_TRAIN, 1'b1);
    end
    idle_inputs();

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    @(negedge clk);
    rst = 1'b0;
    exp_wc = 0;
    exp_err = 0;
    step(1'b1, 64'd5, 1'b0, S_TRAIN, 1'b0);
    idle_inputs();

    repeat (3) @(negedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcg_stream_checker.md
# lcg_stream_checker

Receive-side checker for the 64-bit LCG state stream that feeds the PCG permutation stage. It consumes one word per valid cycle and checks it against the prediction made from the previous word, using next = MULT·prev + INC mod 2^64. The checker self-synchronises with no seed input, declares lock after a run of consecutive correct predictions, and reports errors once locked. It sits on the LCG-to-permutation tap as a built-in self-test for each PCG instance.

## Interface
- MULT, 64'd6364136223846793005, LCG multiplier; must equal the generator's constant.
- INC, 64'd1442695040888963407, LCG increment; must equal the generator's constant.
- LOCK_COUNT, 4, consecutive matches required to enter LOCKED (legal range 1..255).
- ERR_W, 16, width of the error counter.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear: forces IDLE and zeroes both counters.
- in_valid  in  1  in_data is a new stream word this cycle; there is no backpressure and every valid cycle is accepted.
- in_data  in  64  LCG state word.
- locked  out  1  high while the state is LOCKED.
- mismatch  out  1  one-cycle pulse: a word accepted in LOCKED failed its prediction.
- err_count  out  ERR_W  number of mismatches counted in LOCKED; saturates at all-ones.
- word_count  out  32  number of accepted words; wraps modulo 2^32.
- state  out  2  00 IDLE, 01 TRAIN, 10 LOCKED, 11 unused.

## Operation
- Internal registers:
  - pred (64 bits): the expected next word.
  - run (8 bits): the current count of consecutive matches.
- On every accepted word w, in any state:
  - pred <= MULT·w + INC, keeping the low 64 bits of the product and sum; all carries beyond bit 63 are discarded.
  - word_count <= word_count + 1.
- hit = (w == pred), evaluated against pred as it stood before this word's update.
- IDLE:
  - The first accepted word only loads pred.
  - Transition to TRAIN with run = 0.
- TRAIN:
  - On hit: run <= run + 1. If run + 1 == LOCK_COUNT, go to LOCKED and set run <= 0.
  - On a miss: run <= 0, remain in TRAIN. No mismatch pulse; err_count is unchanged.
- LOCKED:
  - On hit: remain in LOCKED.
  - On a miss:
    - mismatch = 1 for one cycle.
    - err_count increments unless it is already all-ones.
    - Go to TRAIN with run = 0.
    - pred reloads from the offending word, so the checker resynchronises to the new sequence.
- Cycles with in_valid = 0 change nothing; mismatch is 0 on those cycles.
- State 11 is unreachable. If it is ever entered, the next clock forces IDLE.
- clear = 1:
  - state <= IDLE; run, err_count and word_count <= 0; mismatch <= 0.
  - pred holds its value but is ignored in IDLE.
  - A word presented in the same cycle is dropped and not counted: clear has priority over in_valid.

## Timing
- Reset (asynchronous, active-high) sets:
  - state = IDLE, locked = 0, mismatch = 0, err_count = 0, word_count = 0.
  - run = 0, pred = 0.
- Latency: a word accepted at rising edge t updates state, locked, mismatch and both counters at that same edge, so the outputs are valid in the cycle after acceptance.
- All outputs are registered; there are no combinational paths from input to output.
- Throughput: one word per clock, including back-to-back words.
- The 64×64 low-half multiply lies in a single register-to-register path from in_data to pred. It must close timing at the generator's clock; pipelining this path is out of scope.
- If rst asserts mid-stream, it takes effect immediately and asynchronously. The next valid word after release is treated as a first word (IDLE).

## Test plan
- Reset, then feed 5 consecutive correct words starting at 0 (second word 1442695040888963407, remainder from the golden model) -> state 01 after word 1; locked = 1 one cycle after word 5; err_count = 0; word_count = 5.
- While locked, corrupt one word by flipping bit 0 -> mismatch pulses exactly once; err_count = 1; state = 01.
  - Then resume the generator's correct sequence -> the first word after the corrupted one misses, since pred was derived from the corrupted word, so run stays 0; the next 4 hit; locked returns after 5 correct words with err_count still 1.
- In TRAIN, alternate correct and corrupted words for 20 words -> locked never asserts, mismatch never pulses, err_count = 0, word_count = 20.
- With ERR_W = 2, force 5 mismatches, each separated by a relock -> err_count sticks at 3.
- Assert clear in the same cycle as a valid word while locked -> state = 00, counters = 0 and the word is not counted. Assert rst asynchronously between clock edges -> all outputs go to their reset values before the next edge.
- Drive in_valid low for 10 cycles between correct words while locked -> no state change, no mismatch, word_count unchanged during the gap.
